// File: rtl/pc_gen.sv
// Fetch program counter: sequential stepping, prioritised redirects with
// capture across global stalls, and a fault state for misaligned targets.
module pc_gen #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RST_VEC   = 32'h0000_0000,
    parameter int unsigned NUM_REDIR = 3,
    parameter int          C_EXT     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hold_n,
    input  logic [NUM_REDIR-1:0]        redir_en,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_to,
    input  logic                        step_half,
    input  logic                        pc_ready,
    output logic                        pc_valid,
    output logic [ADDR_W-1:0]           addr_instr,
    output logic                        redir_taken,
    output logic                        misalign
);

    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RST_VEC);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                taken_q, taken_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0]   pend_tgt_q, pend_tgt_d;

    logic [ADDR_W-1:0]   redir_tgt [NUM_REDIR];
    logic                live_hit;
    logic [ADDR_W-1:0]   live_tgt;
    logic                eff_hit;
    logic [ADDR_W-1:0]   eff_tgt;
    logic                eff_misaligned;
    logic [ADDR_W-1:0]   step;

    for (genvar gi = 0; gi < NUM_REDIR; gi++) begin : g_unpack
        assign redir_tgt[gi] = redir_to[gi*ADDR_W +: ADDR_W];
    end

    // Scan from the top so the lowest asserted channel is the last writer.
    always_comb begin
        live_hit = 1'b0;
        live_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_en[i]) begin
                live_hit = 1'b1;
                live_tgt = redir_tgt[i];
            end
        end
    end

    assign eff_hit        = live_hit | pend_vld_q;
    assign eff_tgt        = live_hit ? live_tgt : pend_tgt_q;
    assign eff_misaligned = eff_tgt[0] | ((C_EXT == 0) && eff_tgt[1]);
    assign step           = ((C_EXT != 0) && step_half) ? ADDR_W'(2) : ADDR_W'(4);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        taken_d    = taken_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        if (!hold_n) begin
            // Frozen pipeline still records the newest redirect request.
            if (live_hit) begin
                pend_vld_d = 1'b1;
                pend_tgt_d = live_tgt;
            end
        end else if (eff_hit) begin
            addr_d     = eff_tgt;
            taken_d    = 1'b1;
            pend_vld_d = 1'b0;
            state_d    = eff_misaligned ? ST_FAULT : ST_RUN;
        end else begin
            taken_d = 1'b0;
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_RUN:   if (pc_ready) addr_d = addr_q + step;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            addr_q     <= RST_ADDR;
            taken_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            taken_q    <= taken_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_valid    = (state_q == ST_RUN);
    assign misalign    = (state_q == ST_FAULT);
    assign addr_instr  = addr_q;
    assign redir_taken = taken_q;

endmodule
